// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel SPI ADC reader: FSM encoding and a
// constant-width helper used to size counters.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sck_gen.sv
// Serial clock generator: toggles sck every CLK_DIV clk cycles while enabled,
// and flags the cycle in which sck is about to rise or fall.
module sck_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic sck_o,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             tick_c;

  always_comb begin
    div_d  = div_q;
    sck_d  = sck_q;
    tick_c = enable_i && (div_q == DIV_W'(CLK_DIV - 1));
    if (!enable_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (tick_c) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign rise_c = tick_c && !sck_q;
  assign fall_c = tick_c && sck_q;
  assign sck_o  = sck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_adc_multi.sv
// Frame controller for a multi-channel serial ADC: strobes ad_conv, clocks out
// one frame over SPI, demultiplexes channel data and publishes it atomically.
module spi_adc_multi
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned NCH       = 2,
  parameter int unsigned LEAD_BITS = 2,
  parameter int unsigned TAIL_BITS = 2,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CONV_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  adc_out,
  output logic                  ad_conv,
  output logic                  spi_sck,
  output logic                  busy,
  output logic                  end_conv,
  output logic [NCH*DATA_W-1:0] data_out,
  output logic                  missed
);

  localparam int unsigned SLOT   = LEAD_BITS + DATA_W;
  localparam int unsigned FRAME  = NCH * SLOT + TAIL_BITS;
  localparam int unsigned CNT_W  = clog2(FRAME + 1);
  localparam int unsigned POS_W  = clog2(SLOT);
  localparam int unsigned CH_W   = clog2(NCH + 1);
  localparam int unsigned CONV_W = clog2(CONV_CYC);

  state_e                       state_q, state_d;
  logic [CONV_W-1:0]            conv_q, conv_d;
  logic [CNT_W-1:0]             bit_q, bit_d;
  logic [POS_W-1:0]             pos_q, pos_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [NCH-1:0][DATA_W-1:0]   shreg_q, shreg_d;
  logic [NCH-1:0][DATA_W-1:0]   data_q, data_d;
  logic                         ad_conv_q, ad_conv_d;
  logic                         end_conv_q, end_conv_d;
  logic                         busy_q, busy_d;
  logic                         missed_q, missed_d;

  logic                         sck_en_c;
  logic                         sck_rise_c;
  logic                         sck_fall_c;

  assign sck_en_c = (state_q == ST_SHIFT);

  sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (sck_en_c),
    .sck_o    (spi_sck),
    .rise_c   (sck_rise_c),
    .fall_c   (sck_fall_c)
  );

  // Next-state and datapath; slot position/channel counters avoid a divider.
  always_comb begin
    state_d    = state_q;
    conv_d     = conv_q;
    bit_d      = bit_q;
    pos_d      = pos_q;
    ch_d       = ch_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    ad_conv_d  = ad_conv_q;
    end_conv_d = 1'b0;
    missed_d   = missed_q;

    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d   = ST_CONV;
          ad_conv_d = 1'b1;
          conv_d    = '0;
        end
        if (start) begin
          missed_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (conv_q == CONV_W'(CONV_CYC - 1)) begin
          state_d   = ST_SHIFT;
          ad_conv_d = 1'b0;
          bit_d     = '0;
          pos_d     = '0;
          ch_d      = '0;
        end else begin
          conv_d = conv_q + CONV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (sck_rise_c) begin
          bit_d = bit_q + CNT_W'(1);
          if (pos_q == POS_W'(SLOT - 1)) begin
            pos_d = '0;
            ch_d  = ch_q + CH_W'(1);
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
          if ((ch_q < CH_W'(NCH)) && (pos_q >= POS_W'(LEAD_BITS))) begin
            for (int k = 0; k < NCH; k++) begin
              if (ch_q == CH_W'(k)) begin
                shreg_d[k] = DATA_W'({shreg_q[k], adc_out});
              end
            end
          end
        end
        // Last falling edge of the frame: publish every channel at once.
        if (sck_fall_c && (bit_q == CNT_W'(FRAME))) begin
          state_d    = ST_DONE;
          end_conv_d = 1'b1;
          data_d     = shreg_q;
        end
      end
      ST_DONE: begin
        if (continuous) begin
          state_d   = ST_CONV;
          ad_conv_d = 1'b1;
          conv_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start && (state_q != ST_IDLE)) begin
      missed_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      conv_q     <= '0;
      bit_q      <= '0;
      pos_q      <= '0;
      ch_q       <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      ad_conv_q  <= 1'b0;
      end_conv_q <= 1'b0;
      busy_q     <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_q     <= conv_d;
      bit_q      <= bit_d;
      pos_q      <= pos_d;
      ch_q       <= ch_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      ad_conv_q  <= ad_conv_d;
      end_conv_q <= end_conv_d;
      busy_q     <= busy_d;
      missed_q   <= missed_d;
    end
  end

  assign ad_conv  = ad_conv_q;
  assign end_conv = end_conv_q;
  assign busy     = busy_q;
  assign missed   = missed_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_spi_adc_multi.sv
// Directed bench for spi_adc_multi: a default 2-channel instance and a 4-channel
// instance, each fed by a simple serial ADC model replaying a prepared bit stream.
module tb_spi_adc_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, cont_a, adc_a;
  logic        ad_conv_a, sck_a, busy_a, endc_a, missed_a;
  logic [27:0] data_a;
  logic        start_b, cont_b, adc_b;
  logic        ad_conv_b, sck_b, busy_b, endc_b, missed_b;
  logic [47:0] data_b;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] stream_a = '0;
  logic [63:0] stream_b = '0;
  logic [6:0]  idx_a = '0;
  logic [6:0]  idx_b = '0;
  logic        sck_prev_a = 1'b0;
  logic        sck_prev_b = 1'b0;
  int          rises_a = 0;
  int          rises_b = 0;
  int          conv_a = 0;
  int          endc_cnt_a = 0;
  int          endc_cnt_b = 0;
  longint      t_last_b = 0;
  longint      t_prev_b = 0;

  int r0, c0, e0;

  spi_adc_multi u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .continuous (cont_a),
    .adc_out    (adc_a),
    .ad_conv    (ad_conv_a),
    .spi_sck    (sck_a),
    .busy       (busy_a),
    .end_conv   (endc_a),
    .data_out   (data_a),
    .missed     (missed_a)
  );

  spi_adc_multi #(
    .DATA_W    (12),
    .NCH       (4),
    .LEAD_BITS (3),
    .TAIL_BITS (0),
    .CLK_DIV   (3),
    .CONV_CYC  (2)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .continuous (cont_b),
    .adc_out    (adc_b),
    .ad_conv    (ad_conv_b),
    .spi_sck    (sck_b),
    .busy       (busy_b),
    .end_conv   (endc_b),
    .data_out   (data_b),
    .missed     (missed_b)
  );

  always #5 clk = ~clk;

  // ADC models: bit index restarts on ad_conv and advances after each SCK rise.
  always @(posedge clk) begin
    sck_prev_a <= sck_a;
    sck_prev_b <= sck_b;
    if (ad_conv_a) idx_a <= '0;
    else if (sck_a && !sck_prev_a) idx_a <= idx_a + 7'd1;
    if (ad_conv_b) idx_b <= '0;
    else if (sck_b && !sck_prev_b) idx_b <= idx_b + 7'd1;
    if (sck_a && !sck_prev_a) rises_a <= rises_a + 1;
    if (sck_b && !sck_prev_b) begin
      rises_b  <= rises_b + 1;
      t_prev_b <= t_last_b;
      t_last_b <= longint'($time);
    end
    if (ad_conv_a) conv_a <= conv_a + 1;
    if (endc_a) endc_cnt_a <= endc_cnt_a + 1;
    if (endc_b) endc_cnt_b <= endc_cnt_b + 1;
  end

  always_comb adc_a = stream_a[idx_a[5:0]];
  always_comb adc_b = stream_b[idx_b[5:0]];

  function automatic logic [63:0] mk_stream(input int nch, input int dw, input int lead,
                                            input int tail, input logic [127:0] d,
                                            input logic lf, input logic tf);
    logic [63:0] s;
    int slot;
    s = '0;
    slot = lead + dw;
    for (int i = 0; i < nch * slot + tail; i++) begin
      if (i >= nch * slot) s[i] = tf;
      else if ((i % slot) < lead) s[i] = lf;
      else s[i] = d[(i / slot) * dw + dw - 1 - ((i % slot) - lead)];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_end(input string tag, input bit sel_b, input int maxc);
    int n;
    n = 0;
    while (((sel_b ? endc_b : endc_a) !== 1'b1) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sel_b ? endc_b : endc_a, 1'b1);
  endtask

  task automatic wait_rises_a(input string tag, input int target, input int maxc);
    int n;
    n = 0;
    while ((rises_a < target) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(rises_a), 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    cont_a  = 1'b0;
    start_b = 1'b0;
    cont_b  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ad_conv", ad_conv_a, 1'b0);
    chk("rst_sck", sck_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_end_conv", endc_a, 1'b0);
    chk("rst_missed", missed_a, 1'b0);
    chk("rst_data", data_a, 28'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame with default parameters
    stream_a = mk_stream(2, 14, 2, 2, {14'h1234, 14'h2A5C}, 1'b0, 1'b0);
    r0 = rises_a; c0 = conv_a; e0 = endc_cnt_a;
    pulse_start(1'b0);
    chk("single_busy", busy_a, 1'b1);
    wait_end("single_end", 1'b0, 400);
    chk("single_data", data_a, {14'h1234, 14'h2A5C});
    @(negedge clk);
    chk("single_idle", busy_a, 1'b0);
    repeat (10) @(negedge clk);
    chk("single_rises", 64'(rises_a - r0), 64'd34);
    chk("single_conv_cyc", 64'(conv_a - c0), 64'd2);
    chk("single_endc_cnt", 64'(endc_cnt_a - e0), 64'd1);

    // Continuous mode over three frames, dropped during the third
    e0 = endc_cnt_a;
    stream_a = mk_stream(2, 14, 2, 2, {14'h3FFF, 14'h0001}, 1'b1, 1'b1);
    @(negedge clk);
    cont_a = 1'b1;
    wait_end("cont0_end", 1'b0, 400);
    chk("cont0_data", data_a, {14'h3FFF, 14'h0001});
    stream_a = mk_stream(2, 14, 2, 2, {14'h1555, 14'h2AAA}, 1'b0, 1'b1);
    @(negedge clk);
    chk("cont0_reconv", ad_conv_a, 1'b1);
    wait_end("cont1_end", 1'b0, 400);
    chk("cont1_data", data_a, {14'h1555, 14'h2AAA});
    stream_a = mk_stream(2, 14, 2, 2, {14'h0ABC, 14'h3210}, 1'b1, 1'b0);
    @(negedge clk);
    chk("cont1_reconv", ad_conv_a, 1'b1);
    repeat (20) @(negedge clk);
    cont_a = 1'b0;
    wait_end("cont2_end", 1'b0, 400);
    chk("cont2_data", data_a, {14'h0ABC, 14'h3210});
    @(negedge clk);
    chk("cont2_no_reconv", ad_conv_a, 1'b0);
    chk("cont2_idle", busy_a, 1'b0);
    repeat (60) @(negedge clk);
    chk("cont_endc_cnt", 64'(endc_cnt_a - e0), 64'd3);

    // Start while busy sets missed without disturbing the frame
    stream_a = mk_stream(2, 14, 2, 2, {14'h2222, 14'h1111}, 1'b1, 1'b0);
    r0 = rises_a; e0 = endc_cnt_a;
    pulse_start(1'b0);
    chk("miss_pre", missed_a, 1'b0);
    wait_rises_a("miss_bit10", r0 + 10, 200);
    pulse_start(1'b0);
    chk("miss_set", missed_a, 1'b1);
    wait_end("miss_end", 1'b0, 400);
    chk("miss_data", data_a, {14'h2222, 14'h1111});
    chk("miss_sticky", missed_a, 1'b1);
    repeat (5) @(negedge clk);
    chk("miss_endc_cnt", 64'(endc_cnt_a - e0), 64'd1);
    stream_a = mk_stream(2, 14, 2, 2, {14'h30C3, 14'h0F0F}, 1'b0, 1'b1);
    pulse_start(1'b0);
    chk("miss_clear", missed_a, 1'b0);
    wait_end("miss2_end", 1'b0, 400);
    chk("miss2_data", data_a, {14'h30C3, 14'h0F0F});

    // Reset in the middle of a frame aborts it
    repeat (3) @(negedge clk);
    stream_a = mk_stream(2, 14, 2, 2, {14'h3AAA, 14'h0555}, 1'b0, 1'b0);
    r0 = rises_a;
    pulse_start(1'b0);
    wait_rises_a("abort_bit20", r0 + 20, 200);
    e0 = endc_cnt_a;
    reset = 1'b1;
    #1;
    chk("abort_sck", sck_a, 1'b0);
    chk("abort_ad_conv", ad_conv_a, 1'b0);
    chk("abort_data", data_a, 28'h0);
    chk("abort_busy", busy_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_endc", 64'(endc_cnt_a - e0), 64'd0);
    chk("abort_stay_idle", busy_a, 1'b0);
    pulse_start(1'b0);
    wait_end("abort_fresh_end", 1'b0, 400);
    chk("abort_fresh_data", data_a, {14'h3AAA, 14'h0555});

    // Lead and tail bits driven high with zero data must be discarded
    repeat (3) @(negedge clk);
    stream_a = mk_stream(2, 14, 2, 2, 128'h0, 1'b1, 1'b1);
    pulse_start(1'b0);
    wait_end("discard_end", 1'b0, 400);
    chk("discard_data", data_a, 28'h0);

    // Four-channel instance with a slower SCK
    stream_b = mk_stream(4, 12, 3, 0, {12'h000, 12'hFFF, 12'h123, 12'hABC}, 1'b1, 1'b0);
    r0 = rises_b; e0 = endc_cnt_b;
    pulse_start(1'b1);
    wait_end("b_end", 1'b1, 1000);
    chk("b_data", data_b, 48'h000FFF123ABC);
    repeat (10) @(negedge clk);
    chk("b_rises", 64'(rises_b - r0), 64'd60);
    chk("b_sck_period", 64'(t_last_b - t_prev_b), 64'd60);
    chk("b_endc_cnt", 64'(endc_cnt_b - e0), 64'd1);
    chk("b_idle", busy_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
